// File: rtl/ma_stage_if.sv
// rtl/ma_stage_if.sv - data-memory req/ack bus between the MA stage and data memory
interface ma_stage_if;
  logic        req;
  logic        we;
  logic [29:0] adr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, adr, be, wdata, input ack, rdata);
  modport slave  (input req, we, adr, be, wdata, output ack, rdata);
endinterface

// File: rtl/ma_stage.sv
// rtl/ma_stage.sv - memory-access pipeline stage with byte-lane steering, load alignment and WB/WB2 taps
// Optional feature macro: MA_TIMEOUT_EN (abort a WAIT that sees no ack within TIMEOUT_CYCLES)
module ma_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_ld_ma,
  input  logic        cmd_st_ma,
  input  logic [4:0]  rd_adr_ma,
  input  logic [31:0] rd_data_ma,
  input  logic        wbk_rd_reg_ma,
  input  logic [31:0] st_data_ma,
  input  logic [2:0]  ldst_code_ma,
  input  logic        stall,
  input  logic        rst_pipe,
  ma_stage_if.master  dmem,
  output logic        ma_stall,
  output logic        ma_misalign,
  output logic [4:0]  rd_adr_wb,
  output logic        wbk_rd_reg_wb,
  output logic [31:0] wbk_data_wb,
  output logic [4:0]  rd_adr_wb2,
  output logic        wbk_rd_reg_wb2,
  output logic [31:0] wbk_data_wb2
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t      state, state_nxt;
  logic [1:0]  lo;
  logic        mem_op, mis, acc, req_raw, ack_v, advance;
  logic        tmo_hit, ld_kill;
  logic [3:0]  be_raw;
  logic [31:0] wdata_raw, ld_fresh, ld_data, hold_data;

  assign lo     = rd_data_ma[1:0];
  assign mem_op = cmd_ld_ma | cmd_st_ma;
  assign mis    = mem_op & (((ldst_code_ma[1:0] == 2'b01) & lo[0]) |
                            ((ldst_code_ma[1:0] == 2'b10) & (lo != 2'b00)));
  assign acc    = mem_op & ~mis;

`ifdef MA_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_flag;

  assign tmo_hit = (state == WAIT) & ~dmem.ack & (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign ld_kill = tmo_hit | tmo_flag;

  // Count unanswered WAIT cycles; remember an abort that parks in HOLD so the load is still dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else if (rst_pipe) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      tmo_cnt <= (state == WAIT && state_nxt == WAIT) ? tmo_cnt + 16'd1 : 16'd0;
      if (state_nxt != HOLD)
        tmo_flag <= 1'b0;
      else if (tmo_hit)
        tmo_flag <= 1'b1;
    end
  end
`else
  // No abort hardware: the comparison is constant-false and only keeps the parameter referenced
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
  assign ld_kill = 1'b0;
`endif

  // Next-state and request: issue once, wait for ack, park in HOLD if the pipe is stalled at completion
  always_comb begin
    state_nxt = state;
    req_raw   = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          req_raw = 1'b1;
          if (dmem.ack) state_nxt = stall ? HOLD : IDLE;
          else          state_nxt = WAIT;
        end
      end
      WAIT: begin
        req_raw = 1'b1;
        if (dmem.ack || tmo_hit) state_nxt = stall ? HOLD : IDLE;
      end
      HOLD: begin
        if (!stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ack_v    = dmem.ack & req_raw;
  assign ma_stall = acc & ~ack_v & (state != HOLD) & ~tmo_hit;
  assign advance  = ~ma_stall & ~stall;

  // Byte-lane enables, replicated store data and aligned/extended load data
  always_comb begin
    be_raw    = 4'b1111;
    wdata_raw = st_data_ma;
    ld_fresh  = dmem.rdata;
    case (ldst_code_ma[1:0])
      2'b00: begin
        be_raw    = 4'b0001 << lo;
        wdata_raw = {4{st_data_ma[7:0]}};
      end
      2'b01: begin
        be_raw    = lo[1] ? 4'b1100 : 4'b0011;
        wdata_raw = {2{st_data_ma[15:0]}};
      end
      default: ;
    endcase
    case (ldst_code_ma)
      3'b000: ld_fresh = {{24{dmem.rdata[8*lo+7]}}, dmem.rdata[8*lo +: 8]};
      3'b100: ld_fresh = {24'd0, dmem.rdata[8*lo +: 8]};
      3'b001: ld_fresh = lo[1] ? {{16{dmem.rdata[31]}}, dmem.rdata[31:16]}
                               : {{16{dmem.rdata[15]}}, dmem.rdata[15:0]};
      3'b101: ld_fresh = lo[1] ? {16'd0, dmem.rdata[31:16]} : {16'd0, dmem.rdata[15:0]};
      default: ;
    endcase
  end

  assign ld_data     = (state == HOLD) ? hold_data : ld_fresh;
  assign dmem.req    = req_raw & ~rst_pipe;
  assign dmem.we     = dmem.req & cmd_st_ma;
  assign dmem.adr    = dmem.req ? rd_data_ma[31:2] : 30'd0;
  assign dmem.be     = dmem.req ? be_raw : 4'd0;
  assign dmem.wdata  = dmem.req ? wdata_raw : 32'd0;

  // State register and the load word captured when completion has to wait out a stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_data <= '0;
    end else if (rst_pipe) begin
      state     <= IDLE;
      hold_data <= '0;
    end else begin
      state <= state_nxt;
      if (state != HOLD && state_nxt == HOLD) hold_data <= ld_fresh;
    end
  end

  // WB and WB+1 forwarding registers, plus the error pulse, all move only on advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_adr_wb      <= '0;
      wbk_rd_reg_wb  <= 1'b0;
      wbk_data_wb    <= '0;
      rd_adr_wb2     <= '0;
      wbk_rd_reg_wb2 <= 1'b0;
      wbk_data_wb2   <= '0;
      ma_misalign    <= 1'b0;
    end else if (rst_pipe) begin
      rd_adr_wb      <= '0;
      wbk_rd_reg_wb  <= 1'b0;
      wbk_data_wb    <= '0;
      rd_adr_wb2     <= '0;
      wbk_rd_reg_wb2 <= 1'b0;
      wbk_data_wb2   <= '0;
      ma_misalign    <= 1'b0;
    end else begin
      ma_misalign <= advance & (mis | (mem_op & ld_kill));
      if (advance) begin
        rd_adr_wb      <= rd_adr_ma;
        wbk_rd_reg_wb  <= wbk_rd_reg_ma & ~cmd_st_ma & ~mis & ~(cmd_ld_ma & ld_kill);
        wbk_data_wb    <= cmd_ld_ma ? ld_data : rd_data_ma;
        rd_adr_wb2     <= rd_adr_wb;
        wbk_rd_reg_wb2 <= wbk_rd_reg_wb;
        wbk_data_wb2   <= wbk_data_wb;
      end
    end
  end

endmodule

// File: tb/tb_ma_stage.sv
// tb/tb_ma_stage.sv - directed table-driven bench for ma_stage
module tb_ma_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_ld_ma = 1'b0, cmd_st_ma = 1'b0, wbk_rd_reg_ma = 1'b0;
  logic [4:0]  rd_adr_ma = '0;
  logic [31:0] rd_data_ma = '0, st_data_ma = '0;
  logic [2:0]  ldst_code_ma = '0;
  logic        stall = 1'b0, rst_pipe = 1'b0;
  logic        ma_stall, ma_misalign, wbk_rd_reg_wb, wbk_rd_reg_wb2;
  logic [4:0]  rd_adr_wb, rd_adr_wb2;
  logic [31:0] wbk_data_wb, wbk_data_wb2;

  int total = 0;
  int bad = 0;

  ma_stage_if bus ();

  ma_stage dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_ld_ma(cmd_ld_ma), .cmd_st_ma(cmd_st_ma), .rd_adr_ma(rd_adr_ma),
    .rd_data_ma(rd_data_ma), .wbk_rd_reg_ma(wbk_rd_reg_ma), .st_data_ma(st_data_ma),
    .ldst_code_ma(ldst_code_ma), .stall(stall), .rst_pipe(rst_pipe),
    .dmem(bus),
    .ma_stall(ma_stall), .ma_misalign(ma_misalign),
    .rd_adr_wb(rd_adr_wb), .wbk_rd_reg_wb(wbk_rd_reg_wb), .wbk_data_wb(wbk_data_wb),
    .rd_adr_wb2(rd_adr_wb2), .wbk_rd_reg_wb2(wbk_rd_reg_wb2), .wbk_data_wb2(wbk_data_wb2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld, st;
    logic [31:0] adr, sd;
    logic [2:0]  code;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_wben;
    logic [31:0] e_wbdata;
    logic        e_mis;
  } vec_t;

  vec_t v[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_ld_ma = 0; cmd_st_ma = 0; wbk_rd_reg_ma = 0; rd_adr_ma = 0; rd_data_ma = 0;
    st_data_ma = 0; ldst_code_ma = 0; stall = 0; rst_pipe = 0;
    bus.ack = 0; bus.rdata = 0;
  endtask

  initial begin
    logic [31:0] prev_wb;
    int n_stall, n_req;

    v[0] = '{1'b1, 1'b0, 32'h100, 32'h0,        3'b010, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 4'b1111, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    v[1] = '{1'b1, 1'b0, 32'h103, 32'h0,        3'b000, 1'b1, 32'h80112233, 1'b1, 1'b0, 4'b1000, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0};
    v[2] = '{1'b0, 1'b1, 32'h202, 32'h0000ABCD, 3'b001, 1'b1, 32'h0,        1'b1, 1'b1, 4'b1100, 32'hABCDABCD, 1'b0, 32'h00000202, 1'b0};
    v[3] = '{1'b1, 1'b0, 32'h101, 32'h0,        3'b010, 1'b0, 32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h0,        1'b1};
    v[4] = '{1'b0, 1'b1, 32'h001, 32'h12345678, 3'b000, 1'b1, 32'h0,        1'b1, 1'b1, 4'b0010, 32'h78787878, 1'b0, 32'h00000001, 1'b0};
    v[5] = '{1'b1, 1'b0, 32'h002, 32'h0,        3'b101, 1'b1, 32'h87650000, 1'b1, 1'b0, 4'b1100, 32'h0,        1'b1, 32'h00008765, 1'b0};
    v[6] = '{1'b1, 1'b0, 32'h000, 32'h0,        3'b001, 1'b1, 32'h1234F00D, 1'b1, 1'b0, 4'b0011, 32'h0,        1'b1, 32'hFFFFF00D, 1'b0};
    v[7] = '{1'b0, 1'b0, 32'hCAFEF00D, 32'h0,   3'b000, 1'b1, 32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0};
    v[8] = '{1'b1, 1'b0, 32'h102, 32'h0,        3'b100, 1'b1, 32'h00AB0000, 1'b1, 1'b0, 4'b0100, 32'h0,        1'b1, 32'h000000AB, 1'b0};
    v[9] = '{1'b0, 1'b1, 32'h103, 32'h55,       3'b010, 1'b0, 32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h00000103, 1'b1};

    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("reset req", {31'd0, bus.req}, 32'd0);
    chk("reset ma_stall", {31'd0, ma_stall}, 32'd0);
    chk("reset wb_data", wbk_data_wb, 32'd0);
    chk("reset wb2_data", wbk_data_wb2, 32'd0);
    chk("reset misalign", {31'd0, ma_misalign}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single-cycle table: every access acked in the issuing cycle, no external stall
    prev_wb = 32'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cmd_ld_ma = v[i].ld; cmd_st_ma = v[i].st; rd_data_ma = v[i].adr; st_data_ma = v[i].sd;
      ldst_code_ma = v[i].code; bus.ack = v[i].ack; bus.rdata = v[i].rdata;
      wbk_rd_reg_ma = 1'b1; rd_adr_ma = 5'(i + 1);
      #2;
      chk($sformatf("v%0d req", i), {31'd0, bus.req}, {31'd0, v[i].e_req});
      chk($sformatf("v%0d we", i), {31'd0, bus.we}, {31'd0, v[i].e_we});
      chk($sformatf("v%0d be", i), {28'd0, bus.be}, {28'd0, v[i].e_be});
      chk($sformatf("v%0d wdata", i), bus.wdata, v[i].e_wdata);
      chk($sformatf("v%0d adr", i), {2'd0, bus.adr}, v[i].e_req ? {2'd0, v[i].adr[31:2]} : 32'd0);
      chk($sformatf("v%0d ma_stall", i), {31'd0, ma_stall}, 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d wb_en", i), {31'd0, wbk_rd_reg_wb}, {31'd0, v[i].e_wben});
      chk($sformatf("v%0d wb_data", i), wbk_data_wb, v[i].e_wbdata);
      chk($sformatf("v%0d rd_adr_wb", i), {27'd0, rd_adr_wb}, 32'(i + 1));
      chk($sformatf("v%0d misalign", i), {31'd0, ma_misalign}, {31'd0, v[i].e_mis});
      chk($sformatf("v%0d wb2_data", i), wbk_data_wb2, prev_wb);
      prev_wb = v[i].e_wbdata;
    end

    // LB 0x103 acked after three wait cycles
    @(negedge clk);
    idle_inputs();
    cmd_ld_ma = 1; wbk_rd_reg_ma = 1; rd_adr_ma = 5'd7; rd_data_ma = 32'h103;
    ldst_code_ma = 3'b000; bus.rdata = 32'h80112233;
    n_stall = 0;
    n_req = 0;
    for (int k = 0; k < 4; k++) begin
      bus.ack = (k == 3);
      #2;
      if (ma_stall) n_stall++;
      if (bus.req) n_req++;
      chk($sformatf("lbwait adr k%0d", k), {2'd0, bus.adr}, 32'h40);
      @(posedge clk);
      #1;
      if (k < 3) chk($sformatf("lbwait wb frozen k%0d", k), wbk_data_wb, 32'h00000103);
      if (k < 3) @(negedge clk);
    end
    chk("lbwait stall cycles", n_stall, 3);
    chk("lbwait req cycles", n_req, 4);
    chk("lbwait wb_data", wbk_data_wb, 32'hFFFFFF80);
    chk("lbwait wb_en", {31'd0, wbk_rd_reg_wb}, 32'd1);

    // LHU 0x2 acked under external stall: one request, then HOLD keeps the captured half
    @(negedge clk);
    idle_inputs();
    cmd_ld_ma = 1; wbk_rd_reg_ma = 1; rd_adr_ma = 5'd9; rd_data_ma = 32'h2;
    ldst_code_ma = 3'b101; stall = 1; bus.ack = 1; bus.rdata = 32'h87650000;
    n_req = 0;
    n_stall = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) bus.rdata = 32'hFFFFFFFF;
      if (k == 2) begin stall = 0; bus.ack = 0; end
      #2;
      if (bus.req) n_req++;
      if (ma_stall) n_stall++;
      @(posedge clk);
      #1;
      if (k < 2) chk($sformatf("hold wb frozen k%0d", k), wbk_data_wb, 32'hFFFFFF80);
      if (k < 2) @(negedge clk);
    end
    chk("hold req count", n_req, 1);
    chk("hold ma_stall count", n_stall, 0);
    chk("hold wb_data", wbk_data_wb, 32'h00008765);
    chk("hold rd_adr_wb", {27'd0, rd_adr_wb}, 32'd9);

    // flush while waiting for ack; a late ack afterwards must be ignored
    @(negedge clk);
    idle_inputs();
    cmd_ld_ma = 1; wbk_rd_reg_ma = 1; rd_adr_ma = 5'd3; rd_data_ma = 32'h100; ldst_code_ma = 3'b010;
    #2;
    chk("flush ma_stall in wait", {31'd0, ma_stall}, 32'd1);
    @(negedge clk);
    rst_pipe = 1;
    @(negedge clk);
    idle_inputs();
    bus.ack = 1; bus.rdata = 32'h12345678;
    #2;
    chk("flush req", {31'd0, bus.req}, 32'd0);
    chk("flush ma_stall", {31'd0, ma_stall}, 32'd0);
    chk("flush wb_en", {31'd0, wbk_rd_reg_wb}, 32'd0);
    chk("flush wb_data", wbk_data_wb, 32'd0);
    chk("flush wb2_data", wbk_data_wb2, 32'd0);
    chk("flush rd_adr_wb", {27'd0, rd_adr_wb}, 32'd0);
    @(posedge clk);
    #1;
    chk("late ack wb_data", wbk_data_wb, 32'd0);
    chk("late ack wb_en", {31'd0, wbk_rd_reg_wb}, 32'd0);
    chk("late ack misalign", {31'd0, ma_misalign}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
